// File: rtl/d_mem_access_unit_pkg.sv
// Shared types and widths for the uncached MEM-stage data access unit.
package d_mem_access_unit_pkg;

  localparam int unsigned ADDR_WIDTH = 26;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_action_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    DONE
  } d_mem_state_t;

endpackage

// File: rtl/d_mem_access_unit_if.sv
// Pipeline-side request/completion signals and the ready/valid memory port.
interface d_mem_access_unit_if;
  import d_mem_access_unit_pkg::*;

  logic                  i_valid;
  mem_action_t           i_mem_action;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_advance;
  logic                  i_flush;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_busy;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_write;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_data;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;

  modport master (
    input  i_valid, i_mem_action, i_addr, i_data, i_advance, i_flush,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output o_valid, o_data, o_busy,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data
  );

  modport slave (
    output i_valid, i_mem_action, i_addr, i_data, i_advance, i_flush,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  o_valid, o_data, o_busy,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data
  );

endinterface

// File: rtl/d_mem_access_unit.sv
// Single-outstanding uncached data access unit: captures one MEM request, issues it on
// the memory port and reports completion; flushed reads drain their response.
module d_mem_access_unit
  import d_mem_access_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  d_mem_access_unit_if.master bus
);

  d_mem_state_t          state_q, state_d;
  mem_action_t           action_q, action_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d  = state_q;
    action_d = action_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_valid && !bus.i_flush) begin
          state_d  = REQ;
          action_d = bus.i_mem_action;
          addr_d   = bus.i_addr;
          wdata_d  = bus.i_data;
        end
      end
      REQ: begin
        // An accepted read still owes a response, so a flush must drain it.
        if (bus.i_flush) begin
          state_d = (bus.mem_req_ready && action_q == READ) ? DRAIN : IDLE;
        end else if (bus.mem_req_ready) begin
          state_d = (action_q == WRITE) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (bus.i_flush) begin
          state_d = bus.mem_resp_valid ? IDLE : DRAIN;
        end else if (bus.mem_resp_valid) begin
          rdata_d = bus.mem_resp_data;
          state_d = DONE;
        end
      end
      DRAIN: begin
        if (bus.mem_resp_valid) state_d = IDLE;
      end
      DONE: begin
        if (bus.i_flush || bus.i_advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    bus.o_valid       = (state_q == DONE);
    bus.o_data        = rdata_q;
    bus.o_busy        = (state_q != IDLE);
    bus.mem_req_valid = (state_q == REQ);
    bus.mem_req_write = (action_q == WRITE);
    bus.mem_req_addr  = addr_q;
    bus.mem_req_data  = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      action_q <= READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      action_q <= action_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // A response is only legal while a read is outstanding.
  resp_in_window: assert property (@(posedge clk) disable iff (rst)
    bus.mem_resp_valid |-> (state_q == WAIT || state_q == DRAIN));

endmodule

// File: tb/tb_d_mem_access_unit.sv
// Self-checking bench: table of single requests through a latency-programmable memory
// model, plus hand-written flush and reset sequences.
module tb_d_mem_access_unit;
  import d_mem_access_unit_pkg::*;

  typedef struct {
    mem_action_t           act;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;       // store data, or read response data
    int                    ready_wait; // REQ cycles with ready low before accept
    int                    resp_lat;
    int                    exp_lat;    // capture cycle to first o_valid
    logic [DATA_WIDTH-1:0] exp_data;
  } vec_t;

  typedef struct {
    logic [DATA_WIDTH-1:0] data;
    int                    lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  d_mem_access_unit_if dif();

  d_mem_access_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  vec_t vecs[8];
  logic [DATA_WIDTH-1:0] last_rd = '0;

  // Memory model controls and observations
  int                    ready_wait = 0;
  int                    resp_lat = 0;
  logic [DATA_WIDTH-1:0] rd_data = '0;
  int                    wr_count = 0;
  int                    rd_count = 0;
  logic [ADDR_WIDTH-1:0] wr_addr = '0;
  logic [DATA_WIDTH-1:0] wr_data = '0;

  // Memory model: inputs change at negedge; an offer made here is consumed at the next posedge.
  initial begin
    int                    req_cycles = 0;
    int                    lat_cnt = 0;
    bit                    pending = 1'b0;
    bit                    offer = 1'b0;
    bit                    offer_write = 1'b0;
    bit                    offer_rst = 1'b0;
    logic [ADDR_WIDTH-1:0] offer_addr = '0;
    logic [DATA_WIDTH-1:0] offer_data = '0;
    dif.mem_req_ready  = 1'b0;
    dif.mem_resp_valid = 1'b0;
    dif.mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      dif.mem_resp_valid = 1'b0;
      if (offer && !offer_rst) begin
        if (offer_write) begin
          wr_count++;
          wr_addr = offer_addr;
          wr_data = offer_data;
        end else begin
          rd_count++;
          pending = 1'b1;
          lat_cnt = resp_lat;
        end
      end
      if (pending) begin
        if (lat_cnt == 0) begin
          dif.mem_resp_valid = 1'b1;
          dif.mem_resp_data  = rd_data;
          pending = 1'b0;
        end else begin
          lat_cnt--;
        end
      end
      if (rst) pending = 1'b0;
      if (dif.mem_req_valid && !rst) begin
        dif.mem_req_ready = (req_cycles >= ready_wait);
        req_cycles++;
      end else begin
        dif.mem_req_ready = 1'b0;
        req_cycles = 0;
      end
      offer       = dif.mem_req_valid && dif.mem_req_ready;
      offer_write = dif.mem_req_write;
      offer_addr  = dif.mem_req_addr;
      offer_data  = dif.mem_req_data;
      offer_rst   = rst;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fields(input vec_t v);
    dif.i_valid      = 1'b1;
    dif.i_mem_action = v.act;
    dif.i_addr       = v.addr;
    dif.i_data       = (v.act == WRITE) ? v.data : ~v.data;
    ready_wait       = v.ready_wait;
    resp_lat         = v.resp_lat;
    if (v.act == READ) rd_data = v.data;
  endtask

  task automatic finish_req(input string nm, input vec_t v, input int wr0, input int rd0);
    int                    cyc;
    int                    req_cyc;
    bit                    stable;
    exp_t                  e;
    logic [DATA_WIDTH-1:0] wd;
    cyc = 0;
    req_cyc = 0;
    stable = 1'b1;
    wd = (v.act == WRITE) ? v.data : ~v.data;
    while (!dif.o_valid && cyc < 100) begin
      tick();
      cyc++;
      if (dif.mem_req_valid) begin
        req_cyc++;
        if (dif.mem_req_addr !== v.addr || dif.mem_req_data !== wd ||
            dif.mem_req_write !== (v.act == WRITE)) stable = 1'b0;
      end
    end
    e = exp_q.pop_front();
    if (!dif.o_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: o_valid 0 after %0d cycles, expected 1", nm, cyc);
      return;
    end
    check({nm, "_lat"}, 64'(cyc), 64'(e.lat));
    check({nm, "_odata"}, 64'(dif.o_data), 64'(e.data));
    check({nm, "_req_cycles"}, 64'(req_cyc), 64'(v.ready_wait + 1));
    check({nm, "_req_stable"}, 64'(stable), 64'(1));
    dif.i_advance = 1'b0;
    tick();
    check({nm, "_hold"}, 64'({dif.o_valid, dif.o_data}), 64'({1'b1, e.data}));
    if (v.act == WRITE) begin
      check({nm, "_wr_issue"}, 64'({wr_count - wr0, wr_addr, wr_data}),
            64'({1, v.addr, v.data}));
    end else begin
      check({nm, "_rd_issue"}, 64'(rd_count - rd0), 64'(1));
      last_rd = v.data;
    end
    dif.i_advance = 1'b1;
    tick();
    dif.i_advance = 1'b0;
    dif.i_valid = 1'b0;
    check({nm, "_retire"}, 64'({dif.o_busy, dif.o_valid}), 64'(0));
  endtask

  task automatic run_req(input string nm, input vec_t v);
    int wr0;
    int rd0;
    wr0 = wr_count;
    rd0 = rd_count;
    drive_fields(v);
    exp_q.push_back('{data: v.exp_data, lat: v.exp_lat});
    finish_req(nm, v, wr0, rd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   wr0;
    int   rd0;
    bit   quiet;
    vecs[0] = '{READ,  26'h000_0123, 32'hDEAD_BEEF, 0, 2, 5, 32'hDEAD_BEEF};
    vecs[1] = '{WRITE, 26'h200_0010, 32'h0000_CAFE, 3, 0, 5, 32'hDEAD_BEEF};
    vecs[2] = '{READ,  26'h000_0010, 32'h1111_1111, 0, 0, 3, 32'h1111_1111};
    vecs[3] = '{READ,  26'h000_0011, 32'h2222_2222, 1, 1, 5, 32'h2222_2222};
    vecs[4] = '{WRITE, 26'h3FF_FFFF, 32'hFFFF_FFFF, 0, 0, 2, 32'h2222_2222};
    vecs[5] = '{READ,  26'h3FF_FFFF, 32'hA5A5_A5A5, 2, 3, 8, 32'hA5A5_A5A5};
    vecs[6] = '{READ,  26'h000_0000, 32'h600D_F00D, 0, 0, 3, 32'h600D_F00D};
    vecs[7] = '{WRITE, 26'h000_0155, 32'h1234_5678, 1, 0, 3, 32'h600D_F00D};

    rst = 1'b1;
    dif.i_valid = 1'b0;
    dif.i_mem_action = READ;
    dif.i_addr = '0;
    dif.i_data = '0;
    dif.i_advance = 1'b0;
    dif.i_flush = 1'b0;
    repeat (3) tick();
    check("reset_ctrl", 64'({dif.o_valid, dif.o_busy, dif.mem_req_valid, dif.mem_req_write}),
          64'(0));
    check("reset_data", 64'({dif.o_data, dif.mem_req_data}), 64'(0));
    check("reset_addr", 64'(dif.mem_req_addr), 64'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_req($sformatf("v%0d", i), vecs[i]);

    // Flush while idle blocks capture
    v = '{READ, 26'h000_0040, 32'h0404_0404, 0, 0, 0, 32'h0};
    drive_fields(v);
    dif.i_flush = 1'b1;
    tick();
    dif.i_flush = 1'b0;
    dif.i_valid = 1'b0;
    check("idle_flush_blocks", 64'({dif.o_busy, dif.mem_req_valid}), 64'(0));

    // Flush in WAIT, response 4 cycles later, new request held during DRAIN
    v = '{READ, 26'h000_0200, 32'hBAD0_BAD0, 0, 5, 0, 32'h0};
    drive_fields(v);
    tick();                                    // REQ, accepted
    tick();                                    // WAIT
    dif.i_flush = 1'b1;
    tick();                                    // DRAIN
    dif.i_flush = 1'b0;
    check("wait_flush_drain", 64'({dif.o_busy, dif.o_valid, dif.mem_req_valid}), 64'(3'b100));
    v = '{READ, 26'h000_0300, 32'h3030_3030, 0, 1, 4, 32'h3030_3030};
    dif.i_valid = 1'b1;
    dif.i_mem_action = READ;
    dif.i_addr = v.addr;
    dif.i_data = ~v.data;
    quiet = 1'b1;
    repeat (4) begin
      tick();
      if (!dif.o_busy || dif.o_valid || dif.mem_req_valid) quiet = 1'b0;
    end
    check("drain_holds", 64'(quiet), 64'(1));
    tick();
    check("drain_exit", 64'({dif.o_busy, dif.o_valid}), 64'(0));
    check("drain_odata_kept", 64'(dif.o_data), 64'(last_rd));
    run_req("after_drain", v);

    // Flush coincident with accept: READ drains, WRITE retires committed
    v = '{READ, 26'h000_0400, 32'h5555_AAAA, 0, 2, 0, 32'h0};
    rd0 = rd_count;
    drive_fields(v);
    tick();
    dif.i_flush = 1'b1;
    tick();
    dif.i_flush = 1'b0;
    dif.i_valid = 1'b0;
    check("req_flush_rd_drain", 64'({dif.o_busy, dif.o_valid, dif.mem_req_valid}),
          64'(3'b100));
    tick();
    tick();
    check("req_flush_rd_wait_resp", 64'({dif.o_busy, dif.o_valid}), 64'(2'b10));
    tick();
    check("req_flush_rd_idle", 64'({dif.o_busy, dif.o_valid}), 64'(0));
    check("req_flush_rd_issued", 64'(rd_count - rd0), 64'(1));
    check("req_flush_rd_odata", 64'(dif.o_data), 64'(last_rd));

    v = '{WRITE, 26'h000_0500, 32'h0BAD_CAFE, 0, 0, 0, 32'h0};
    wr0 = wr_count;
    drive_fields(v);
    tick();
    dif.i_flush = 1'b1;
    tick();
    dif.i_flush = 1'b0;
    dif.i_valid = 1'b0;
    check("req_flush_wr_idle", 64'({dif.o_busy, dif.o_valid, dif.mem_req_valid}), 64'(0));
    tick();
    check("req_flush_wr_once", 64'({wr_count - wr0, wr_addr, wr_data}),
          64'({1, v.addr, v.data}));

    // Flush in REQ before acceptance: nothing is issued
    v = '{WRITE, 26'h000_0600, 32'h6666_6666, 5, 0, 0, 32'h0};
    wr0 = wr_count;
    drive_fields(v);
    tick();
    dif.i_flush = 1'b1;
    tick();
    dif.i_flush = 1'b0;
    dif.i_valid = 1'b0;
    repeat (3) tick();
    check("req_flush_unaccepted", 64'({wr_count - wr0, 31'(0), dif.o_busy, dif.mem_req_valid}),
          64'(0));

    // Flush in WAIT with the response in the same cycle discards it
    v = '{READ, 26'h000_0700, 32'h0BAD_F00D, 0, 0, 0, 32'h0};
    drive_fields(v);
    tick();
    tick();
    dif.i_flush = 1'b1;
    tick();
    dif.i_flush = 1'b0;
    dif.i_valid = 1'b0;
    check("wait_flush_resp_idle", 64'({dif.o_busy, dif.o_valid}), 64'(0));
    check("wait_flush_resp_discard", 64'(dif.o_data), 64'(last_rd));

    // Reset in WAIT with the late response arriving in the reset cycle
    v = '{READ, 26'h000_0800, 32'h7777_8888, 0, 3, 0, 32'h0};
    drive_fields(v);
    repeat (4) tick();
    check("rst_pre_wait", 64'({dif.o_busy, dif.o_valid, dif.mem_req_valid}), 64'(3'b100));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dif.i_valid = 1'b0;
    check("rst_wait_ctrl", 64'({dif.o_valid, dif.o_busy, dif.mem_req_valid, dif.mem_req_write}),
          64'(0));
    check("rst_wait_data", 64'({dif.o_data, dif.mem_req_data}), 64'(0));
    check("rst_wait_addr", 64'(dif.mem_req_addr), 64'(0));
    tick();
    tick();
    check("rst_late_resp_ignored", 64'({dif.o_data, dif.o_busy, dif.o_valid}), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
